// File: rtl/flag_loader_if.sv
// flag_loader_if: byte stream handshake into the flag loader.
//   byte_data  - ASCII flag byte (producer -> loader)
//   byte_valid - byte_data is valid (producer -> loader)
//   byte_ready - loader takes the byte on this edge (loader -> producer)
// master = byte producer (host/UART side), slave = flag_loader.
`timescale 1ns/1ps

interface flag_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/flag_loader.sv
// flag_loader: packs NBYTES ASCII bytes MSB-first into a flag word for the
// combinational checker, waits CHECK_LAT cycles for it to settle, then
// captures the verdict into registered done/pass.
// Ports:
//   clk, rst_n    - clock (rising edge), async active-low reset
//   bif (slave)   - byte_data/byte_valid/byte_ready stream
//   restart       - one-cycle pulse: drop contents, return to loading
//   flag          - packed flag word, drives the checker input
//   flag_valid    - flag complete and stable
//   check_result  - checker verdict
//   done, pass    - verdict captured / captured verdict
//   byte_count    - bytes accepted so far (0..NBYTES)
//   fmt_err       - sticky format violation
// Optional: define FLAG_FORMAT_CHECK_EN to check the "ictf{" prefix and the
// closing '}'; a violation forces pass to 0. Without it fmt_err stays 0.
`timescale 1ns/1ps

module flag_loader #(
    parameter int unsigned NBYTES    = 32,
    parameter int unsigned CHECK_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flag_loader_if.slave          bif,
    input  logic                  restart,
    output logic [NBYTES*8-1:0]   flag,
    output logic                  flag_valid,
    input  logic                  check_result,
    output logic                  done,
    output logic                  pass,
    output logic [5:0]            byte_count,
    output logic                  fmt_err
);

    localparam int unsigned FW = NBYTES * 8;
    localparam int unsigned CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(CHECK_LAT - 1);
    localparam logic [5:0]    LAST_IDX  = 6'(NBYTES - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flag_q, flag_d;
    logic            flag_valid_q, flag_valid_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [5:0]      count_q, count_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            fmt_err_q, fmt_err_d;
    logic            ready_c;
    logic            accept_c;
    logic            fmt_bad_c;
    int unsigned     shamt_c;

    // Restart takes priority over any offered byte.
    assign ready_c        = (state_q == LOAD) && !restart;
    assign accept_c       = ready_c && bif.byte_valid;
    assign bif.byte_ready = ready_c;

`ifdef FLAG_FORMAT_CHECK_EN
    // Expected byte for the current slot; only prefix and last slot are checked.
    always_comb begin
        logic       checked;
        logic [7:0] expect_byte;
        checked     = 1'b1;
        expect_byte = 8'h00;
        case (count_q)
            6'd0:    expect_byte = 8'h69;
            6'd1:    expect_byte = 8'h63;
            6'd2:    expect_byte = 8'h74;
            6'd3:    expect_byte = 8'h66;
            6'd4:    expect_byte = 8'h7B;
            default: checked     = 1'b0;
        endcase
        if (count_q == LAST_IDX) begin
            checked     = 1'b1;
            expect_byte = 8'h7D;
        end
        fmt_bad_c = checked && (bif.byte_data != expect_byte);
    end
`else
    assign fmt_bad_c = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        flag_d       = flag_q;
        flag_valid_d = flag_valid_q;
        done_d       = done_q;
        pass_d       = pass_q;
        count_d      = count_q;
        wait_d       = wait_q;
        fmt_err_d    = fmt_err_q;
        shamt_c      = FW - 8 - 8 * 32'(count_q);

        if (restart) begin
            state_d      = LOAD;
            flag_d       = '0;
            flag_valid_d = 1'b0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            count_d      = '0;
            wait_d       = '0;
            fmt_err_d    = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept_c) begin
                        // Target slot is still zero, so OR-in places the byte.
                        flag_d  = flag_q | (FW'(bif.byte_data) << shamt_c);
                        count_d = count_q + 6'd1;
`ifdef FLAG_FORMAT_CHECK_EN
                        if (fmt_bad_c) fmt_err_d = 1'b1;
`endif
                        if (count_q == LAST_IDX) begin
                            state_d      = CHECK;
                            flag_valid_d = 1'b1;
                            wait_d       = '0;
                        end
                    end
                end
                CHECK: begin
                    // Sample on the CHECK_LAT-th edge after flag_valid rose.
                    if (wait_q == WAIT_LAST) begin
`ifdef FLAG_FORMAT_CHECK_EN
                        pass_d = check_result && !fmt_err_q;
`else
                        pass_d = check_result;
`endif
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            flag_q       <= '0;
            flag_valid_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            count_q      <= '0;
            wait_q       <= '0;
            fmt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flag_q       <= flag_d;
            flag_valid_q <= flag_valid_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign flag       = flag_q;
    assign flag_valid = flag_valid_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign byte_count = count_q;
    assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_flag_loader.sv
// tb_flag_loader: directed bench for flag_loader with a stand-in checker
// that accepts exactly the reference flag "ictf{AAAA...A}".
`timescale 1ns/1ps

module tb_flag_loader;

    localparam logic [255:0] GOLDEN = {40'h696374667B, {26{8'h41}}, 8'h7D};

    logic         clk;
    logic         rst_n;
    logic         restart;
    logic [255:0] flag;
    logic         flag_valid;
    logic         check_result;
    logic         done;
    logic         pass;
    logic [5:0]   byte_count;
    logic         fmt_err;

    logic         cr_force;
    logic         cr_val;

    int total = 0;
    int bad   = 0;

    flag_loader_if bif();

    flag_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bif          (bif.slave),
        .restart      (restart),
        .flag         (flag),
        .flag_valid   (flag_valid),
        .check_result (check_result),
        .done         (done),
        .pass         (pass),
        .byte_count   (byte_count),
        .fmt_err      (fmt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in checker, or a forced verdict when cr_force is set.
    always_comb check_result = cr_force ? cr_val : (flag == GOLDEN);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] fbyte(input int k);
        case (k)
            0:       return 8'h69;
            1:       return 8'h63;
            2:       return 8'h74;
            3:       return 8'h66;
            4:       return 8'h7B;
            31:      return 8'h7D;
            default: return 8'h41;
        endcase
    endfunction

    // Stream 32 bytes; with gap, one idle cycle precedes each byte.
    task automatic load_flag(input bit gap, input logic [7:0] first);
        for (int k = 0; k < 32; k++) begin
            if (gap) begin
                bif.byte_valid = 1'b0;
                @(posedge clk); #1;
                chk("gap_count", 256'(byte_count), 256'(k));
            end
            bif.byte_data  = (k == 0) ? first : fbyte(k);
            bif.byte_valid = 1'b1;
            @(posedge clk); #1;
            chk("load_count", 256'(byte_count), 256'(k + 1));
            chk("load_fvalid", 256'(flag_valid), 256'(k == 31));
        end
        bif.byte_valid = 1'b0;
    endtask

    // Called 1ns after the completing edge: done rises two edges later.
    task automatic verdict(input logic exp_pass);
        chk("done_early0", 256'(done), 256'(0));
        @(posedge clk); #1;
        chk("done_early1", 256'(done), 256'(0));
        @(posedge clk); #1;
        chk("done_rise", 256'(done), 256'(1));
        chk("pass_val", 256'(pass), 256'(exp_pass));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        chk("rst_count", 256'(byte_count), 256'(0));
        chk("rst_flag", flag, 256'(0));
        chk("rst_fvalid", 256'(flag_valid), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        restart        = 1'b0;
        cr_force       = 1'b0;
        cr_val         = 1'b0;
        bif.byte_data  = 8'h00;
        bif.byte_valid = 1'b0;

        // Reset state
        #3;
        chk("reset_count", 256'(byte_count), 256'(0));
        chk("reset_flag", flag, 256'(0));
        chk("reset_fvalid", 256'(flag_valid), 256'(0));
        chk("reset_done", 256'(done), 256'(0));
        chk("reset_pass", 256'(pass), 256'(0));
        chk("reset_fmt", 256'(fmt_err), 256'(0));
        chk("reset_ready", 256'(bif.byte_ready), 256'(1));
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: back-to-back load with checker in the loop
        load_flag(1'b0, 8'h69);
        chk("s1_flag", flag, GOLDEN);
        chk("s1_ready", 256'(bif.byte_ready), 256'(0));
        verdict(1'b1);

        // 2: every-other-cycle load
        do_restart();
        load_flag(1'b1, 8'h69);
        chk("s2_flag", flag, GOLDEN);
        verdict(1'b1);

        // 3: restart beats a simultaneous byte after 10 bytes
        do_restart();
        for (int k = 0; k < 10; k++) begin
            bif.byte_data  = fbyte(k);
            bif.byte_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("s3_count10", 256'(byte_count), 256'(10));
        chk("s3_flag10", flag, {40'h696374667B, 40'h4141414141, 176'h0});
        bif.byte_data = fbyte(10);
        restart       = 1'b1;
        #1;
        chk("s3_ready_low", 256'(bif.byte_ready), 256'(0));
        @(posedge clk); #1;
        restart        = 1'b0;
        bif.byte_valid = 1'b0;
        chk("s3_count0", 256'(byte_count), 256'(0));
        chk("s3_flag0", flag, 256'(0));
        load_flag(1'b0, 8'h69);
        chk("s3_flag", flag, GOLDEN);
        verdict(1'b1);

        // 4b: verdict 0 only on the sampling edge
        do_restart();
        cr_force = 1'b1;
        cr_val   = 1'b1;
        load_flag(1'b0, 8'h69);
        @(posedge clk); #1;
        cr_val = 1'b0;
        @(posedge clk); #1;
        cr_val = 1'b1;
        chk("s4b_done", 256'(done), 256'(1));
        chk("s4b_pass", 256'(pass), 256'(0));
        @(posedge clk); #1;
        chk("s4b_pass_hold", 256'(pass), 256'(0));

        // 4a: verdict 1 only on the sampling edge
        do_restart();
        cr_val = 1'b0;
        load_flag(1'b0, 8'h69);
        @(posedge clk); #1;
        cr_val = 1'b1;
        @(posedge clk); #1;
        cr_val = 1'b0;
        chk("s4a_done", 256'(done), 256'(1));
        chk("s4a_pass", 256'(pass), 256'(1));

        // 5: bytes offered in DONE are refused
        bif.byte_data  = 8'hFF;
        bif.byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("s5_ready", 256'(bif.byte_ready), 256'(0));
        end
        bif.byte_valid = 1'b0;
        chk("s5_flag", flag, GOLDEN);
        chk("s5_count", 256'(byte_count), 256'(32));
        chk("s5_pass", 256'(pass), 256'(1));
        chk("s5_done", 256'(done), 256'(1));
        chk("s5_fvalid", 256'(flag_valid), 256'(1));
        cr_force = 1'b0;

        // 6: async reset in the middle of CHECK
        do_restart();
        load_flag(1'b0, 8'h69);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_fvalid", 256'(flag_valid), 256'(0));
        chk("s6_done", 256'(done), 256'(0));
        chk("s6_pass", 256'(pass), 256'(0));
        chk("s6_flag", flag, 256'(0));
        chk("s6_count", 256'(byte_count), 256'(0));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 6b: bad first byte with a forced passing checker
        cr_force = 1'b1;
        cr_val   = 1'b1;
        load_flag(1'b0, 8'h41);
        chk("s6b_flag", flag, {8'h41, GOLDEN[247:0]});
`ifdef FLAG_FORMAT_CHECK_EN
        chk("s6b_fmt", 256'(fmt_err), 256'(1));
        verdict(1'b0);
`else
        chk("s6b_fmt", 256'(fmt_err), 256'(0));
        verdict(1'b1);
`endif
        cr_force = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_loader.md
Name: flag_loader

Overview:
Byte-serial producer that feeds the 256-bit combinational flag checker.
- Accepts ASCII flag bytes over a valid/ready stream and packs them MSB-first into a 256-bit word.
- Presents the word to the checker, waits a fixed settle time, and samples the checker's verdict into a registered pass/done result.
- Sits between the host/UART byte stream and the `sat` checker instance.

Parameters:
NBYTES, 32, number of bytes per flag; NBYTES*8 must equal the checker input width (256).
CHECK_LAT, 2, cycles from flag_valid rising to sampling check_result; minimum 1.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
byte_data  input  8  incoming flag byte
byte_valid  input  1  byte_data is valid
byte_ready  output  1  loader accepts a byte this cycle
restart  input  1  single-cycle pulse: discard contents and return to LOAD
flag  output  256  packed flag word, drives the checker input
flag_valid  output  1  flag is complete and stable
check_result  input  1  checker verdict (checker output)
done  output  1  verdict captured
pass  output  1  captured verdict
byte_count  output  6  bytes accepted so far (0..NBYTES)
fmt_err  output  1  format violation (see Optional Feature)

Behaviour:
- One clock domain: clk. rst_n is asynchronous, active-low. Assertion immediately forces:
  - state=LOAD, flag=0, flag_valid=0, done=0, pass=0, byte_count=0, fmt_err=0, wait counter=0.
  - Deassertion is synchronized externally.
- byte_ready = (state==LOAD) && !restart. It is combinational and reads 1 out of reset.
- A transfer occurs on a rising clk when byte_valid && byte_ready.
  - Byte k (0-based) is written to flag[255-8k -: 8].
  - byte_count increments.
  - Unloaded bytes remain 0.
- States:
  - LOAD: accept bytes. When the transfer of byte NBYTES-1 completes, go to CHECK and set flag_valid=1 on the same edge; byte_count=NBYTES.
  - CHECK: the wait counter counts clocks since flag_valid rose. On the CHECK_LAT-th edge after flag_valid rose:
    - pass <= check_result (masked per Optional Feature);
    - done <= 1;
    - go to DONE.
    - check_result is ignored on all other cycles.
  - DONE: hold flag, flag_valid=1, done, pass and byte_count stable. byte_ready=0; offered bytes are not accepted.
- restart, in any state:
  - Next edge: state=LOAD, flag=0, flag_valid=0, done=0, pass=0, fmt_err=0, byte_count=0, counter=0.
  - restart beats a simultaneous byte: byte_ready is 0, so no transfer happens.
- flag is registered and changes only on accepted transfers or on restart/reset. It never changes while flag_valid=1.
- byte_count never exceeds NBYTES and does not wrap.
- Back-to-back bytes every cycle are supported. Full load latency is NBYTES cycles. Verdict is at NBYTES+CHECK_LAT edges after the first accept.

Optional Feature:
Macro FLAG_FORMAT_CHECK_EN.
- Defined:
  - Bytes 0..4 are compared against "ictf{" (0x69 0x63 0x74 0x66 0x7B) as they are accepted.
  - Byte NBYTES-1 is compared against '}' (0x7D).
  - Any mismatch sets fmt_err=1 on the accepting edge; it is sticky until restart/reset.
  - Loading still completes. The captured verdict is pass <= check_result && !fmt_err.
- Undefined: fmt_err is tied to 0; pass <= check_result.

Test Plan:
1. Reset, stream "ictf{" + 26 x 0x41 + "}" with byte_valid held high, check_result tied to checker.
   -> byte_count reaches 32 after 32 edges; flag_valid rises on the 32nd edge; flag = 0x696374667b4141...417d; done rises 2 edges later; pass equals the checker output.
2. Same stream with byte_valid asserted every other cycle.
   -> only accepted bytes counted; flag identical to scenario 1; flag_valid after 64 cycles.
3. After 10 bytes, pulse restart together with byte_valid=1.
   -> that byte is not accepted; byte_count=0, flag=0 next edge; a subsequent full load behaves as scenario 1.
4. Force check_result=1 only during the sampling cycle, then repeat with 0 only during the sampling cycle.
   -> pass=1 in the first run, pass=0 in the second, done=1 in both; toggling check_result before or after the sampling cycle has no effect.
5. In DONE, drive byte_valid=1 with 0xFF for 5 cycles.
   -> byte_ready=0; flag, byte_count and pass unchanged.
6. Apply rst_n=0 mid-CHECK (between clk edges).
   -> flag_valid, done, pass, flag, byte_count go to 0 immediately.
   - With FLAG_FORMAT_CHECK_EN defined, first byte 0x41 and check_result=1 -> fmt_err=1, pass=0.
   - Without the macro -> fmt_err=0, pass=1.
